// File: rtl/simt_pkg.sv
// Shared types for the SIMT divergence/reconvergence stack: the stacked entry
// layout and the "no reconvergence pending" sentinel.
package simt_pkg;

    localparam int SIMT_THREADS = 4;
    localparam int SIMT_AW      = 32;

    localparam logic [SIMT_AW-1:0] RPC_NONE = '1;

    typedef struct packed {
        logic [SIMT_THREADS-1:0] mask;
        logic [SIMT_AW-1:0]      pc;
        logic [SIMT_AW-1:0]      rpc;
    } simt_entry_t;

endpackage

// File: rtl/simt_entry_ram.sv
// Entry storage for the reconvergence stack: a divergence writes two adjacent
// slots at once, and the top of stack is read combinationally.
module simt_entry_ram
    import simt_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [IW-1:0] waddr_i,
    input  simt_entry_t wdata0_i,
    input  simt_entry_t wdata1_i,
    input  logic [IW-1:0] raddr_i,
    output simt_entry_t rdata_o
);

    simt_entry_t    mem [DEPTH];
    logic [IW-1:0]  waddr1;

    assign waddr1  = waddr_i + IW'(1);
    assign rdata_o = mem[raddr_i];

    // Reconvergence entry goes below the deferred-path entry so it pops last.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata0_i;
            mem[waddr1]  <= wdata1_i;
        end
    end

endmodule

// File: rtl/simt_reconv_stack.sv
// SIMT divergence/reconvergence unit: tracks the active lane mask and
// reconvergence PC, pushes on divergent branches and pops at the reconvergence PC.
module simt_reconv_stack
    import simt_pkg::*;
#(
    parameter  int THREADS = SIMT_THREADS,
    parameter  int DEPTH   = 8,
    parameter  int AW      = SIMT_AW,
    localparam int DW      = $clog2(DEPTH) + 1,
    localparam int IW      = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               advance_i,
    input  logic               flush_i,
    input  logic               diverge_i,
    input  logic [THREADS-1:0] taken_mask_i,
    input  logic [AW-1:0]      taken_pc_i,
    input  logic [AW-1:0]      fall_pc_i,
    input  logic [AW-1:0]      reconv_pc_i,
    input  logic [AW-1:0]      pc_next_i,
    output logic [THREADS-1:0] active_mask_o,
    output logic [AW-1:0]      cur_rpc_o,
    output logic               redirect_o,
    output logic [AW-1:0]      redirect_pc_o,
    output logic [DW-1:0]      depth_o,
    output logic               full_o,
    output logic               empty_o,
    output logic               overflow_err_o,
    output logic               underflow_err_o
);

    logic [THREADS-1:0] cur_mask_q, cur_mask_d;
    logic [AW-1:0]      cur_rpc_q,  cur_rpc_d;
    logic [DW-1:0]      depth_q,    depth_d;
    logic               full_q,     full_d;
    logic               empty_q,    empty_d;
    logic               ovf_q,      ovf_d;
    logic               unf_q,      unf_d;

    logic [THREADS-1:0] t_mask;
    logic               split, do_push, push_blocked;
    logic               at_rpc, do_pop, pop_empty;
    logic               ram_we;
    simt_entry_t        entry0, entry1, top;

    // A branch only splits the warp when some, but not all, active lanes take it.
    always_comb begin
        t_mask       = taken_mask_i & cur_mask_q;
        split        = diverge_i && (t_mask != '0) && (t_mask != cur_mask_q);
        do_push      = split && !full_q;
        push_blocked = split && full_q;
        at_rpc       = !diverge_i && (pc_next_i == cur_rpc_q);
        do_pop       = at_rpc && !empty_q;
        pop_empty    = at_rpc && empty_q;
        entry0       = '{mask: cur_mask_q, pc: reconv_pc_i, rpc: cur_rpc_q};
        entry1       = '{mask: cur_mask_q & ~t_mask, pc: fall_pc_i, rpc: reconv_pc_i};
        ram_we       = advance_i && !flush_i && do_push;
    end

    simt_entry_ram #(.DEPTH(DEPTH)) u_ram (
        .clk_i    (clk_i),
        .we_i     (ram_we),
        .waddr_i  (depth_q[IW-1:0]),
        .wdata0_i (entry0),
        .wdata1_i (entry1),
        .raddr_i  (depth_q[IW-1:0] - IW'(1)),
        .rdata_o  (top)
    );

    // Redirect is combinational so the PC mux can use it in the same cycle, even on a stall.
    always_comb begin
        redirect_o    = !rst_i && !flush_i && (do_push || do_pop);
        redirect_pc_o = '0;
        if (redirect_o) begin
            redirect_pc_o = do_push ? taken_pc_i : top.pc;
        end
    end

    always_comb begin
        cur_mask_d = cur_mask_q;
        cur_rpc_d  = cur_rpc_q;
        depth_d    = depth_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        if (flush_i) begin
            cur_mask_d = '1;
            cur_rpc_d  = RPC_NONE;
            depth_d    = '0;
            ovf_d      = 1'b0;
            unf_d      = 1'b0;
        end else if (advance_i) begin
            if (do_push) begin
                cur_mask_d = t_mask;
                cur_rpc_d  = reconv_pc_i;
                depth_d    = depth_q + DW'(2);
            end else if (do_pop) begin
                cur_mask_d = top.mask;
                cur_rpc_d  = top.rpc;
                depth_d    = depth_q - DW'(1);
            end
            ovf_d = ovf_q | push_blocked;
            unf_d = unf_q | pop_empty;
        end
        full_d  = depth_d > DW'(DEPTH - 2);
        empty_d = depth_d == '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cur_mask_q <= '1;
            cur_rpc_q  <= RPC_NONE;
            depth_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            cur_mask_q <= cur_mask_d;
            cur_rpc_q  <= cur_rpc_d;
            depth_q    <= depth_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign active_mask_o   = cur_mask_q;
    assign cur_rpc_o       = cur_rpc_q;
    assign depth_o         = depth_q;
    assign full_o          = full_q;
    assign empty_o         = empty_q;
    assign overflow_err_o  = ovf_q;
    assign underflow_err_o = unf_q;

endmodule

// File: tb/tb_simt_reconv_stack.sv
// Directed bench for simt_reconv_stack (THREADS=4, DEPTH=4): a vector table of
// per-cycle inputs with hand-computed outputs, plus an asynchronous reset sequence.
module tb_simt_reconv_stack;

    localparam logic [31:0] N = 32'hFFFFFFFF;

    typedef struct {
        logic        adv, fl, dv;
        logic [3:0]  tm;
        logic [31:0] tpc, fpc, rpc, pcn;
        logic        redir;
        logic [31:0] rpco;
        logic [3:0]  mask;
        logic [31:0] crpc;
        logic [2:0]  dep;
        logic        full, empty, ovf, unf;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        advance_i, flush_i, diverge_i;
    logic [3:0]  taken_mask_i;
    logic [31:0] taken_pc_i, fall_pc_i, reconv_pc_i, pc_next_i;
    logic [3:0]  active_mask_o;
    logic [31:0] cur_rpc_o, redirect_pc_o;
    logic        redirect_o, full_o, empty_o, overflow_err_o, underflow_err_o;
    logic [2:0]  depth_o;

    int total = 0;
    int bad   = 0;
    vec_t vecs [29];

    simt_reconv_stack #(.THREADS(4), .DEPTH(4), .AW(32)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .advance_i       (advance_i),
        .flush_i         (flush_i),
        .diverge_i       (diverge_i),
        .taken_mask_i    (taken_mask_i),
        .taken_pc_i      (taken_pc_i),
        .fall_pc_i       (fall_pc_i),
        .reconv_pc_i     (reconv_pc_i),
        .pc_next_i       (pc_next_i),
        .active_mask_o   (active_mask_o),
        .cur_rpc_o       (cur_rpc_o),
        .redirect_o      (redirect_o),
        .redirect_pc_o   (redirect_pc_o),
        .depth_o         (depth_o),
        .full_o          (full_o),
        .empty_o         (empty_o),
        .overflow_err_o  (overflow_err_o),
        .underflow_err_o (underflow_err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(input logic adv, fl, dv, input logic [3:0] tm,
                                input logic [31:0] tpc, fpc, rpc, pcn,
                                input logic redir, input logic [31:0] rpco,
                                input logic [3:0] mask, input logic [31:0] crpc,
                                input logic [2:0] dep, input logic full, empty, ovf, unf);
        vec_t v;
        v.adv = adv; v.fl = fl; v.dv = dv; v.tm = tm;
        v.tpc = tpc; v.fpc = fpc; v.rpc = rpc; v.pcn = pcn;
        v.redir = redir; v.rpco = rpco; v.mask = mask; v.crpc = crpc;
        v.dep = dep; v.full = full; v.empty = empty; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkState(input string tag, input logic [3:0] mask, input logic [31:0] crpc,
                              input logic [2:0] dep, input logic full, empty, ovf, unf);
        checkOutput({tag, " active_mask"}, 64'(active_mask_o), 64'(mask));
        checkOutput({tag, " cur_rpc"}, 64'(cur_rpc_o), 64'(crpc));
        checkOutput({tag, " depth"}, 64'(depth_o), 64'(dep));
        checkOutput({tag, " full"}, 64'(full_o), 64'(full));
        checkOutput({tag, " empty"}, 64'(empty_o), 64'(empty));
        checkOutput({tag, " overflow_err"}, 64'(overflow_err_o), 64'(ovf));
        checkOutput({tag, " underflow_err"}, 64'(underflow_err_o), 64'(unf));
    endtask

    // Drive one vector just after a rising edge, check redirect mid-cycle, state after the edge.
    task automatic applyStimulus(input int idx, input vec_t v);
        string tag;
        tag          = $sformatf("vec%0d", idx);
        advance_i    = v.adv;
        flush_i      = v.fl;
        diverge_i    = v.dv;
        taken_mask_i = v.tm;
        taken_pc_i   = v.tpc;
        fall_pc_i    = v.fpc;
        reconv_pc_i  = v.rpc;
        pc_next_i    = v.pcn;
        @(negedge clk_i);
        checkOutput({tag, " redirect"}, 64'(redirect_o), 64'(v.redir));
        checkOutput({tag, " redirect_pc"}, 64'(redirect_pc_o), 64'(v.rpco));
        @(posedge clk_i);
        #1;
        checkState(tag, v.mask, v.crpc, v.dep, v.full, v.empty, v.ovf, v.unf);
    endtask

    initial begin
        // Idle, then simple diverge 1010 and its two pops
        vecs[0]  = mk(1,0,0,4'h0,0,0,0,'h4,         0,0,     4'hF,N,    0,0,1,0,0);
        vecs[1]  = mk(1,0,1,4'hA,'h40,'h14,'h80,'h8, 1,'h40, 4'hA,'h80, 2,0,0,0,0);
        vecs[2]  = mk(1,0,0,4'h0,0,0,0,'h44,        0,0,     4'hA,'h80, 2,0,0,0,0);
        vecs[3]  = mk(1,0,0,4'h0,0,0,0,'h80,        1,'h14,  4'h5,'h80, 1,0,0,0,0);
        vecs[4]  = mk(1,0,0,4'h0,0,0,0,'h80,        1,'h80,  4'hF,N,    0,0,1,0,0);
        // Uniform branches
        vecs[5]  = mk(1,0,1,4'hF,'h40,'h14,'h80,'h40, 0,0,   4'hF,N,    0,0,1,0,0);
        vecs[6]  = mk(1,0,1,4'h0,'h40,'h14,'h80,'h14, 0,0,   4'hF,N,    0,0,1,0,0);
        // Nested 1100 / 1000 and four pops
        vecs[7]  = mk(1,0,1,4'hC,'h40,'h14,'h80,'h8, 1,'h40, 4'hC,'h80, 2,0,0,0,0);
        vecs[8]  = mk(1,0,1,4'h8,'h50,'h44,'h60,'h8, 1,'h50, 4'h8,'h60, 4,1,0,0,0);
        vecs[9]  = mk(1,0,0,4'h0,0,0,0,'h60,        1,'h44,  4'h4,'h60, 3,1,0,0,0);
        vecs[10] = mk(1,0,0,4'h0,0,0,0,'h60,        1,'h60,  4'hC,'h80, 2,0,0,0,0);
        vecs[11] = mk(1,0,0,4'h0,0,0,0,'h80,        1,'h14,  4'h3,'h80, 1,0,0,0,0);
        vecs[12] = mk(1,0,0,4'h0,0,0,0,'h80,        1,'h80,  4'hF,N,    0,0,1,0,0);
        // Fill with 1110 / 0110, then a blocked 0100 divergence
        vecs[13] = mk(1,0,1,4'hE,'h40,'h14,'h80,'h8, 1,'h40, 4'hE,'h80, 2,0,0,0,0);
        vecs[14] = mk(1,0,1,4'h6,'h50,'h44,'h60,'h8, 1,'h50, 4'h6,'h60, 4,1,0,0,0);
        vecs[15] = mk(1,0,1,4'h4,'h70,'h54,'h90,'h8, 0,0,    4'h6,'h60, 4,1,0,1,0);
        vecs[16] = mk(1,0,0,4'h0,0,0,0,'h58,        0,0,     4'h6,'h60, 4,1,0,1,0);
        // Stalled pop redirects but holds state; then unwind
        vecs[17] = mk(0,0,0,4'h0,0,0,0,'h60,        1,'h44,  4'h6,'h60, 4,1,0,1,0);
        vecs[18] = mk(1,0,0,4'h0,0,0,0,'h60,        1,'h44,  4'h8,'h60, 3,1,0,1,0);
        vecs[19] = mk(1,0,0,4'h0,0,0,0,'h60,        1,'h60,  4'hE,'h80, 2,0,0,1,0);
        vecs[20] = mk(1,0,0,4'h0,0,0,0,'h80,        1,'h14,  4'h1,'h80, 1,0,0,1,0);
        vecs[21] = mk(1,0,0,4'h0,0,0,0,'h80,        1,'h80,  4'hF,N,    0,0,1,1,0);
        // Flush beats a divergence and clears the sticky error
        vecs[22] = mk(1,1,1,4'hA,'h40,'h14,'h80,'h8, 0,0,    4'hF,N,    0,0,1,0,0);
        // Stalled divergence, then diverge beating a reconvergence match
        vecs[23] = mk(0,0,1,4'hA,'h40,'h14,'h80,'h8, 1,'h40, 4'hF,N,    0,0,1,0,0);
        vecs[24] = mk(1,0,1,4'hA,'h40,'h14,'h80,N,   1,'h40, 4'hA,'h80, 2,0,0,0,0);
        vecs[25] = mk(1,0,1,4'h2,'h48,'h18,'h70,'h80, 1,'h48, 4'h2,'h70, 4,1,0,0,0);
        vecs[26] = mk(1,1,0,4'h0,0,0,0,'h0,         0,0,     4'hF,N,    0,0,1,0,0);
        // Reconvergence match on an empty stack
        vecs[27] = mk(1,0,0,4'h0,0,0,0,N,           0,0,     4'hF,N,    0,0,1,0,1);
        vecs[28] = mk(1,0,0,4'h0,0,0,0,'h4,         0,0,     4'hF,N,    0,0,1,0,1);

        rst_i = 1'b1;
        advance_i = 1'b0; flush_i = 1'b0; diverge_i = 1'b0; taken_mask_i = '0;
        taken_pc_i = '0; fall_pc_i = '0; reconv_pc_i = '0; pc_next_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        checkState("reset", 4'hF, N, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("reset redirect", 64'(redirect_o), 64'd0);

        for (int i = 0; i < 29; i++) begin
            applyStimulus(i, vecs[i]);
        end

        // Asynchronous reset mid-run with a divergence outstanding and underflow set
        applyStimulus(29, mk(1,0,1,4'h3,'h40,'h14,'h80,'h8, 1,'h40, 4'h3,'h80, 2,0,0,0,1));
        advance_i = 1'b0;
        diverge_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        checkState("midrst", 4'hF, N, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        applyStimulus(30, mk(1,0,0,4'h0,0,0,0,'h4, 0,0, 4'hF,N, 0,0,1,0,0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
